// File: rtl/urv_shift_arbiter.sv
// urv_shift_arbiter: shares the two-stage urv_shifter between requester A
// (execute-stage shifts) and requester B (auxiliary alignment unit).
// Tracks which requester owns the op in shifter stage 2 and stalls the
// shifter to hold a result that its owner has not yet consumed.
// Build option: URV_SHIFT_ARB_RR_EN selects round-robin arbitration.
// Without it, A has fixed priority and B is forced through after
// B_STARVE_LIMIT consecutive refused cycles.
//
// state   | meaning
// S_EMPTY | no op in shifter stage 2
// S_OWN_A | stage 2 holds an op issued by A (BUSY/HOLD set by a_rsp_ready_i)
// S_OWN_B | stage 2 holds an op issued by B (BUSY/HOLD set by b_rsp_ready_i)
module urv_shift_arbiter #(
  parameter int B_STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_stall_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [31:0] a_rs1_i,
  input  logic [4:0]  a_shamt_i,
  input  logic [2:0]  a_fun_i,
  input  logic        a_sign_i,
  output logic        a_rsp_valid_o,
  input  logic        a_rsp_ready_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [31:0] b_rs1_i,
  input  logic [4:0]  b_shamt_i,
  input  logic [2:0]  b_fun_i,
  input  logic        b_sign_i,
  output logic        b_rsp_valid_o,
  input  logic        b_rsp_ready_i,
  output logic [31:0] rsp_rd_o,
  output logic        sh_valid_o,
  output logic        sh_is_shift_o,
  output logic [31:0] sh_rs1_o,
  output logic [4:0]  sh_shamt_o,
  output logic [2:0]  sh_fun_o,
  output logic        sh_sign_o,
  output logic        sh_stall_o,
  input  logic [31:0] sh_rd_i
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_s2_valid;
  logic w_owner_b;
  logic w_owner_rdy;
  logic w_grant_a;
  logic w_grant_b;

`ifdef URV_SHIFT_ARB_RR_EN
  logic r_rr_last;
`else
  localparam logic [3:0] LP_LIMIT = 4'(B_STARVE_LIMIT);
  logic [3:0] r_starve_cnt;
  logic       w_b_force;
`endif

  // Stage-2 occupancy and owner; reset discards any in-flight op.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

`ifdef URV_SHIFT_ARB_RR_EN
  // Remember the last grantee so the other side wins the next contention.
  always_ff @(posedge clk_i) begin
    if (rst_i)          r_rr_last <= 1'b1;
    else if (w_grant_a) r_rr_last <= 1'b0;
    else if (w_grant_b) r_rr_last <= 1'b1;
  end
`else
  // Count consecutive cycles in which B asked, issue was open, and A won.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    r_starve_cnt <= 4'd0;
    else if (!b_valid_i)          r_starve_cnt <= 4'd0;
    else if (w_grant_b)           r_starve_cnt <= 4'd0;
    else if (!sh_stall_o)         r_starve_cnt <= r_starve_cnt + 4'd1;
  end
`endif

  // Arbitration, shifter drive, response handshake and next stage-2 state.
  always_comb begin
    w_s2_valid    = (r_state == S_OWN_A) || (r_state == S_OWN_B);
    w_owner_b     = (r_state == S_OWN_B);
    w_owner_rdy   = w_owner_b ? b_rsp_ready_i : a_rsp_ready_i;
    sh_stall_o    = core_stall_i | (w_s2_valid & ~w_owner_rdy);
    rsp_rd_o      = sh_rd_i;
    a_rsp_valid_o = ~rst_i & w_s2_valid & ~w_owner_b & ~core_stall_i;
    b_rsp_valid_o = ~rst_i & w_s2_valid &  w_owner_b & ~core_stall_i;

`ifdef URV_SHIFT_ARB_RR_EN
    w_grant_a = a_valid_i & (~b_valid_i | r_rr_last);
`else
    w_b_force = (r_starve_cnt == LP_LIMIT);
    w_grant_a = a_valid_i & ~(b_valid_i & w_b_force);
`endif
    w_grant_b = b_valid_i & ~w_grant_a;
    if (rst_i || sh_stall_o) begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
    end

    a_ready_o     = w_grant_a;
    b_ready_o     = w_grant_b;
    sh_valid_o    = 1'b0;
    sh_is_shift_o = 1'b0;
    sh_rs1_o      = 32'd0;
    sh_shamt_o    = 5'd0;
    sh_fun_o      = 3'd0;
    sh_sign_o     = 1'b0;
    if (w_grant_a) begin
      sh_valid_o    = 1'b1;
      sh_is_shift_o = 1'b1;
      sh_rs1_o      = a_rs1_i;
      sh_shamt_o    = a_shamt_i;
      sh_fun_o      = a_fun_i;
      sh_sign_o     = a_sign_i;
    end else if (w_grant_b) begin
      sh_valid_o    = 1'b1;
      sh_is_shift_o = 1'b1;
      sh_rs1_o      = b_rs1_i;
      sh_shamt_o    = b_shamt_i;
      sh_fun_o      = b_fun_i;
      sh_sign_o     = b_sign_i;
    end

    w_state_nxt = r_state;
    if (!sh_stall_o) begin
      if (w_grant_a)      w_state_nxt = S_OWN_A;
      else if (w_grant_b) w_state_nxt = S_OWN_B;
      else                w_state_nxt = S_EMPTY;
    end
  end

endmodule

// File: tb/tb_urv_shift_arbiter.sv
// Directed testbench for urv_shift_arbiter with a behavioural one-cycle
// shifter model that freezes while sh_stall_o is high.
module tb_urv_shift_arbiter;

  localparam logic [2:0] FUNC_SL = 3'b001;
  localparam logic [2:0] FUNC_SR = 3'b101;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_stall_i;
  logic        a_valid_i, a_ready_o, a_sign_i, a_rsp_valid_o, a_rsp_ready_i;
  logic        b_valid_i, b_ready_o, b_sign_i, b_rsp_valid_o, b_rsp_ready_i;
  logic [31:0] a_rs1_i, b_rs1_i, rsp_rd_o, sh_rs1_o, sh_rd_i;
  logic [4:0]  a_shamt_i, b_shamt_i, sh_shamt_o;
  logic [2:0]  a_fun_i, b_fun_i, sh_fun_o;
  logic        sh_valid_o, sh_is_shift_o, sh_sign_o, sh_stall_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  urv_shift_arbiter #(.B_STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_stall_i(core_stall_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_rs1_i(a_rs1_i),
    .a_shamt_i(a_shamt_i), .a_fun_i(a_fun_i), .a_sign_i(a_sign_i),
    .a_rsp_valid_o(a_rsp_valid_o), .a_rsp_ready_i(a_rsp_ready_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_rs1_i(b_rs1_i),
    .b_shamt_i(b_shamt_i), .b_fun_i(b_fun_i), .b_sign_i(b_sign_i),
    .b_rsp_valid_o(b_rsp_valid_o), .b_rsp_ready_i(b_rsp_ready_i),
    .rsp_rd_o(rsp_rd_o), .sh_valid_o(sh_valid_o), .sh_is_shift_o(sh_is_shift_o),
    .sh_rs1_o(sh_rs1_o), .sh_shamt_o(sh_shamt_o), .sh_fun_o(sh_fun_o),
    .sh_sign_o(sh_sign_o), .sh_stall_o(sh_stall_o), .sh_rd_i(sh_rd_i)
  );

  // Shifter model: result of the op presented in cycle N appears in N+1.
  always @(posedge clk_i) begin
    if (!sh_stall_o) begin
      if (sh_fun_o == FUNC_SL)  sh_rd_i <= sh_rs1_o << sh_shamt_o;
      else if (sh_sign_o)       sh_rd_i <= 32'($signed(sh_rs1_o) >>> sh_shamt_o);
      else                      sh_rd_i <= sh_rs1_o >> sh_shamt_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] rs1, input logic [4:0] sh,
                         input logic [2:0] fn, input logic sg);
    a_valid_i = v; a_rs1_i = rs1; a_shamt_i = sh; a_fun_i = fn; a_sign_i = sg;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] rs1, input logic [4:0] sh,
                         input logic [2:0] fn, input logic sg);
    b_valid_i = v; b_rs1_i = rs1; b_shamt_i = sh; b_fun_i = fn; b_sign_i = sg;
  endtask

  initial begin
    logic exp_a, exp_b;
    rst_i = 1'b1; core_stall_i = 1'b0;
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    drive_b(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    a_rsp_ready_i = 1'b1; b_rsp_ready_i = 1'b1;
    step();
    #1;
    chk("rst_sh_valid", sh_valid_o, 0);
    chk("rst_a_rsp_valid", a_rsp_valid_o, 0);
    chk("rst_b_rsp_valid", b_rsp_valid_o, 0);
    chk("rst_sh_stall", sh_stall_o, 0);
    step();
    rst_i = 1'b0;

    // 1: single A arithmetic right shift
    drive_a(1'b1, 32'h8000_0001, 5'd4, FUNC_SR, 1'b1);
    #1;
    chk("t1_a_ready", a_ready_o, 1);
    chk("t1_sh_valid", sh_valid_o, 1);
    chk("t1_sh_rs1", sh_rs1_o, 32'h8000_0001);
    chk("t1_b_ready", b_ready_o, 0);
    step();
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    #1;
    chk("t1_a_rsp_valid", a_rsp_valid_o, 1);
    chk("t1_rsp_rd", rsp_rd_o, 32'hF800_0000);
    chk("t1_b_rsp_valid", b_rsp_valid_o, 0);
    chk("t1_sh_valid_idle", sh_valid_o, 0);
    chk("t1_sh_rs1_idle", sh_rs1_o, 0);
    step();
    chk("t1_a_rsp_done", a_rsp_valid_o, 0);

    // 2: back-to-back A issues
    drive_a(1'b1, 32'h1, 5'd1, FUNC_SL, 1'b0);
    #1;
    chk("t2_a_ready0", a_ready_o, 1);
    step();
    drive_a(1'b1, 32'h1, 5'd31, FUNC_SL, 1'b0);
    #1;
    chk("t2_a_ready1", a_ready_o, 1);
    chk("t2_rsp0_valid", a_rsp_valid_o, 1);
    chk("t2_rsp0", rsp_rd_o, 32'h2);
    chk("t2_stall0", sh_stall_o, 0);
    step();
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    #1;
    chk("t2_rsp1_valid", a_rsp_valid_o, 1);
    chk("t2_rsp1", rsp_rd_o, 32'h8000_0000);
    chk("t2_stall1", sh_stall_o, 0);
    step();

    // 3: B result held while B not ready, A waits
    b_rsp_ready_i = 1'b0;
    drive_b(1'b1, 32'h0000_F000, 5'd8, FUNC_SR, 1'b0);
    #1;
    chk("t3_b_ready", b_ready_o, 1);
    step();
    drive_b(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    drive_a(1'b1, 32'h3, 5'd2, FUNC_SL, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_stall", sh_stall_o, 1);
      chk("t3_hold_rd", rsp_rd_o, 32'h0000_00F0);
      chk("t3_hold_a_ready", a_ready_o, 0);
      chk("t3_hold_b_rsp_valid", b_rsp_valid_o, 1);
      step();
    end
    b_rsp_ready_i = 1'b1;
    #1;
    chk("t3_rel_stall", sh_stall_o, 0);
    chk("t3_rel_a_ready", a_ready_o, 1);
    chk("t3_rel_b_rsp_valid", b_rsp_valid_o, 1);
    chk("t3_rel_rd", rsp_rd_o, 32'h0000_00F0);
    step();
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    #1;
    chk("t3_a_rsp_valid", a_rsp_valid_o, 1);
    chk("t3_a_rsp_rd", rsp_rd_o, 32'hC);
    step();

    // fresh reset so arbitration history starts clean
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;

    // 4: sustained contention
    drive_a(1'b1, 32'h10, 5'd1, FUNC_SL, 1'b0);
    drive_b(1'b1, 32'h20, 5'd1, FUNC_SR, 1'b0);
    for (int i = 0; i < 18; i++) begin
      #1;
`ifdef URV_SHIFT_ARB_RR_EN
      exp_b = (i % 2) == 1;
`else
      exp_b = (i % 9) == 8;
`endif
      exp_a = ~exp_b;
      chk($sformatf("t4_a_ready_%0d", i), a_ready_o, exp_a);
      chk($sformatf("t4_b_ready_%0d", i), b_ready_o, exp_b);
      step();
    end
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    drive_b(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    step();

    // 5: core stall with A op in stage 2
    drive_a(1'b1, 32'h1234_5678, 5'd4, FUNC_SL, 1'b0);
    #1;
    chk("t5_a_ready", a_ready_o, 1);
    step();
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    drive_b(1'b1, 32'h1, 5'd1, FUNC_SL, 1'b0);
    core_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_stall_rsp_valid", a_rsp_valid_o, 0);
      chk("t5_stall_b_ready", b_ready_o, 0);
      chk("t5_stall_sh_valid", sh_valid_o, 0);
      chk("t5_stall_sh_stall", sh_stall_o, 1);
      step();
    end
    core_stall_i = 1'b0;
    drive_b(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    #1;
    chk("t5_rsp_valid", a_rsp_valid_o, 1);
    chk("t5_rsp_rd", rsp_rd_o, 32'h2345_6780);
    step();

    // 6: reset while B op in stage 2
    drive_b(1'b1, 32'h1, 5'd5, FUNC_SL, 1'b0);
    #1;
    chk("t6_b_ready", b_ready_o, 1);
    step();
    drive_b(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    drive_a(1'b1, 32'h1, 5'd1, FUNC_SL, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_b_rsp_valid", b_rsp_valid_o, 0);
    chk("t6_rst_a_ready", a_ready_o, 0);
    chk("t6_rst_sh_valid", sh_valid_o, 0);
    step();
    rst_i = 1'b0;
    drive_a(1'b0, 32'd0, 5'd0, FUNC_SL, 1'b0);
    #1;
    chk("t6_post_b_rsp_valid", b_rsp_valid_o, 0);
    chk("t6_post_a_rsp_valid", a_rsp_valid_o, 0);
    chk("t6_post_sh_stall", sh_stall_o, 0);
    chk("t6_post_sh_valid", sh_valid_o, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
